pwm_capture: RTL and testbench

Measures an incoming PWM waveform, such as a servo or ESC feedback line or another board's PWM output. It is the receive-side counterpart of the team's N-step PWM generators. It reports high time and period in sysclk cycles, and the duty cycle scaled to DUTY_STEP steps. The duty output uses the same units as the generators' duty input, so a capture/replay loop needs no conversion. A DC or dead input is flagged after a timeout.

---
 rtl/pwm_capture.sv | 195 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty of an async PWM input.
// Results publish together after a sequential restoring divide.
module pwm_capture #(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int DUTY_STEP      = 100,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [31:0]      duty,
  output logic             valid,
  output logic             timeout,
  output logic             overrun
);
  localparam int NW = CNT_W + 8;
  localparam int IW = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);

  if (SYS_CLK_FREQ <= 0 || DUTY_STEP < 2 || DUTY_STEP > 255) begin : g_bad
    $error("pwm_capture: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_TMO
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_s1;
  logic             r_s2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hw;
  logic [CNT_W-1:0] r_lh;
  logic [CNT_W-1:0] r_lp;
  logic [NW-1:0]    r_num;
  logic [CNT_W-1:0] r_rem;
  logic [IW-1:0]    r_it;
  logic             r_busy;

  logic             w_rise;
  logic             w_fall;
  logic             w_cnt_sat;
  logic             w_accept;
  logic             w_req;
  logic             w_drop;
  logic             w_div_last;
  logic             w_div_free;
  logic             w_enter_tmo;
  logic             w_ge;
  logic [CNT_W:0]   w_rem_sh;
  logic [CNT_W:0]   w_rem_sub;
  logic [NW-1:0]    w_num_prod;

  assign w_rise     = r_s2 & ~r_prev;
  assign w_fall     = ~r_s2 & r_prev;
  assign w_cnt_sat  = (r_cnt == TO);
  assign w_div_last = r_busy && (r_it == IW'(NW));
  assign w_div_free = ~r_busy | w_div_last;
  assign w_rem_sh   = {r_rem, r_num[NW-1]};
  assign w_rem_sub  = w_rem_sh - {1'b0, r_lp};
  assign w_ge       = ~w_rem_sub[CNT_W];
  assign w_num_prod = NW'(r_hw) * NW'(DUTY_STEP);

  // Next state plus the per-edge accept / request / drop decisions
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_req       = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_IDLE, S_TMO: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_accept    = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_fall) w_state_nxt = S_LOW;
        else if (w_cnt_sat) w_state_nxt = S_TMO;
      end
      S_LOW: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_accept    = 1'b1;
          w_req       = w_div_free;
          w_drop      = ~w_div_free;
        end else if (w_cnt_sat) begin
          w_state_nxt = S_TMO;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_tmo = (w_state_nxt == S_TMO) && (r_state != S_TMO);

  // Two-flop synchronizer and previous-value register for edge detect
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= pwm_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // FSM state register
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Cycle counter: reload on accepted rise, saturate at the timeout
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p)         r_cnt <= '0;
    else if (w_accept)   r_cnt <= CNT_W'(1);
    else if (!w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
  end

  // High-time capture and latch of the completed period
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_hw <= '0;
      r_lh <= '0;
      r_lp <= '0;
    end else begin
      if (r_state == S_HIGH && w_fall) r_hw <= r_cnt;
      if (w_req) begin
        r_lh <= r_hw;
        r_lp <= r_cnt;
      end
    end
  end

  // Restoring divider; r_num shifts the quotient in from the bottom
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_busy <= 1'b0;
      r_it   <= '0;
      r_num  <= '0;
      r_rem  <= '0;
    end else if (w_req) begin
      r_busy <= 1'b1;
      r_it   <= '0;
      r_num  <= w_num_prod;
      r_rem  <= '0;
    end else if (w_div_last) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_it  <= r_it + IW'(1);
      r_rem <= w_ge ? w_rem_sub[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
      r_num <= {r_num[NW-2:0], w_ge};
    end
  end

  // Result publication, timeout entry values and status pulses
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid   <= w_div_last;
      overrun <= w_drop;
      if (w_div_last) begin
        high_cnt   <= r_lh;
        period_cnt <= r_lp;
        duty       <= {24'd0, r_num[7:0]};
        timeout    <= 1'b0;
      end
      if (w_enter_tmo) begin
        timeout    <= 1'b1;
        period_cnt <= '0;
        duty       <= r_s2 ? 32'(DUTY_STEP) : 32'd0;
        high_cnt   <= r_s2 ? TO : '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random PWM stimulus against a period-level model.
// Checks results, latency, overrun, timeout and reset behaviour.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int CW   = 32;
  localparam int STEP = 100;
  localparam int TMO  = 3000;
  localparam int GAP  = CW + 9;
  localparam int LAT  = 3 + CW + 9;

  logic          clk = 1'b0;
  logic          reset_p;
  logic          pwm_in;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic [31:0]   duty;
  logic          valid;
  logic          timeout;
  logic          overrun;

  pwm_capture #(
    .SYS_CLK_FREQ  (100_000_000),
    .DUTY_STEP     (STEP),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .duty      (duty),
    .valid     (valid),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint h;
    longint p;
    longint d;
    longint t;
  } exp_t;

  exp_t   q[$];
  int     ovr_exp = 0;
  int     ovr_obs = 0;
  bit     m_prev  = 1'b0;
  longint m_rise  = 0;
  longint m_h     = 0;
  longint m_req   = -1000;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // a rise at posedge index cyc closes the previous period
  task automatic rise_model(longint h_next);
    longint p;
    exp_t   e;
    if (m_prev) begin
      p = cyc - m_rise;
      if (cyc - m_req >= GAP) begin
        e.h = m_h;
        e.p = p;
        e.d = (m_h * STEP) / p;
        e.t = cyc + LAT;
        q.push_back(e);
        m_req = cyc;
      end else begin
        ovr_exp++;
      end
    end
    m_prev = 1'b1;
    m_rise = cyc;
    m_h    = h_next;
  endtask

  task automatic period(int h, int p);
    rise_model(h);
    pwm_in = 1'b1;
    repeat (h) @(posedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(posedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_tmo"}, timeout, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (!reset_p) begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", valid, 0);
        end else begin
          e = q.pop_front();
          chk("high_cnt", high_cnt, e.h);
          chk("period_cnt", period_cnt, e.p);
          chk("duty", duty, e.d);
          chk("valid_time", cyc, e.t);
          chk("tmo_clr", timeout, 0);
        end
      end
      if (overrun) ovr_obs++;
    end
  end

  initial begin
    int h;
    int p;
    int dl[6];
    reset_p = 1'b1;
    pwm_in  = 1'b0;
    repeat (3) @(posedge clk);
    chk_zero("rst");
    @(posedge clk);
    reset_p = 1'b0;
    repeat (5) @(posedge clk);

    repeat (4) period(250, 1000);
    repeat (3) period(500, 1000);
    repeat (3) period(990, 1000);

    repeat (40) begin
      if ($urandom_range(0, 4) == 0) p = $urandom_range(20, 60);
      else p = $urandom_range(45, 400);
      h = $urandom_range(2, p - 2);
      period(h, p);
    end

    repeat (10) period(15, 30);
    repeat (2) period(200, 400);

    dl = '{1, 37, 50, 99, 0, 0};
    dl[4] = $urandom_range(2, 98);
    dl[5] = $urandom_range(2, 98);
    foreach (dl[i]) repeat (3) period(dl[i], 100);

    repeat (TMO + 200) @(posedge clk);
    m_prev = 1'b0;
    chk("lo_tmo", timeout, 1);
    chk("lo_period", period_cnt, 0);
    chk("lo_duty", duty, 0);
    chk("lo_high", high_cnt, 0);

    period(50, 100);
    chk("tmo_hold", timeout, 1);
    repeat (4) period(50, 100);

    rise_model(0);
    pwm_in = 1'b1;
    repeat (TMO + 200) @(posedge clk);
    m_prev = 1'b0;
    chk("hi_tmo", timeout, 1);
    chk("hi_period", period_cnt, 0);
    chk("hi_duty", duty, STEP);
    chk("hi_high", high_cnt, TMO);

    pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    repeat (4) period(60, 120);
    rise_model(60);
    pwm_in = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    reset_p = 1'b1;
    pwm_in  = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    m_prev = 1'b0;
    m_req  = cyc - 1000;
    @(posedge clk);
    @(posedge clk);
    reset_p = 1'b0;
    repeat (5) @(posedge clk);
    repeat (4) period(100, 200);

    repeat (100) @(posedge clk);
    chk("pending_valids", q.size(), 0);
    chk("overrun_count", ovr_obs, ovr_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
